// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types, constants and operand packing for the calculator
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int NUM_OPERANDS  = 5;
  localparam int NUM_OPERATORS = 4;

  typedef enum logic [1:0] {
    ENTER_NUM = 2'd0,
    ENTER_OP  = 2'd1,
    FULL      = 2'd2
  } entry_state_e;

  // Sign in bit 7, magnitude in bits 1:0, everything between is zero.
  function automatic logic [7:0] pack_operand(input logic sign, input logic [1:0] mag);
    return {sign, 5'b00000, mag};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - KEY synchronizer, optional debouncer, falling-edge press pulse
// Debouncer present only when CALC_ENTRY_DEBOUNCE_EN is defined.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q, edge_d;
  logic level;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    edge_d  = level;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
    end
  end

`ifdef CALC_ENTRY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // Counter runs only while the synchronized level disagrees with the accepted
  // one; any return to the accepted level reloads it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
`else
  logic unused_debounce_cycles;
  assign unused_debounce_cycles = (DEBOUNCE_CYCLES != 0);
  assign level = sync2_q;
`endif

  assign press = edge_q & ~level;

endmodule

// File: rtl/calc_entry_seq.sv
// rtl/calc_entry_seq.sv - press-driven operand/operator entry sequencer for the calculator core
// CALC_ENTRY_DEBOUNCE_EN selects the debounced KEY path inside key_debounce.
module calc_entry_seq
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        KEY,
  input  logic [5:0]  SW,
  input  logic        consume,
  output logic [39:0] numbers,
  output logic [7:0]  operators,
  output logic        valid,
  output logic [3:0]  step,
  output logic        expect_op
);

  entry_state_e state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [39:0]  numbers_q, numbers_d;
  logic [7:0]   operators_q, operators_d;
  logic         press;
  logic         unused_sw3;

  assign unused_sw3 = SW[3];

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (KEY),
    .press (press)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ENTER_NUM;
      idx_q       <= '0;
      numbers_q   <= '0;
      operators_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      numbers_q   <= numbers_d;
      operators_q <= operators_d;
    end
  end

  // SW is only looked at in a press cycle; consume only matters while FULL.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    numbers_d   = numbers_q;
    operators_d = operators_q;
    case (state_q)
      ENTER_NUM: begin
        if (press) begin
          numbers_d[{idx_q, 3'b000} +: 8] = pack_operand(SW[2], SW[1:0]);
          state_d = (idx_q == 3'(NUM_OPERANDS - 1)) ? FULL : ENTER_OP;
        end
      end
      ENTER_OP: begin
        if (press) begin
          operators_d[{idx_q, 1'b0} +: 2] = SW[5:4];
          idx_d   = idx_q + 3'd1;
          state_d = ENTER_NUM;
        end
      end
      FULL: begin
        if (consume) begin
          numbers_d   = '0;
          operators_d = '0;
          idx_d       = '0;
          state_d     = ENTER_NUM;
        end
      end
      default: begin
        state_d = ENTER_NUM;
      end
    endcase
  end

  always_comb begin
    valid     = (state_q == FULL);
    expect_op = (state_q == ENTER_OP);
    step      = valid ? 4'd9 : ({idx_q, 1'b0} + {3'b000, expect_op});
  end

  assign numbers   = numbers_q;
  assign operators = operators_q;

endmodule

// File: tb/tb_calc_entry_seq.sv
// tb/tb_calc_entry_seq.sv - directed self-checking bench for calc_entry_seq
module tb_calc_entry_seq;
  import calc_pkg::*;

  localparam int DEB = 8;
`ifdef CALC_ENTRY_DEBOUNCE_EN
  localparam int PRESS_LAT = DEB + 2;
`else
  localparam int PRESS_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        KEY;
  logic [5:0]  SW;
  logic        consume;
  logic [39:0] numbers;
  logic [7:0]  operators;
  logic        valid;
  logic [3:0]  step;
  logic        expect_op;

  int n_tests = 0;
  int n_fail  = 0;

  calc_entry_seq #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .KEY       (KEY),
    .SW        (SW),
    .consume   (consume),
    .numbers   (numbers),
    .operators (operators),
    .valid     (valid),
    .step      (step),
    .expect_op (expect_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] sw;
    logic [3:0] step;
    logic       eop;
    logic       vld;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [7:0] exp_byte(input logic [5:0] s);
    return {s[2], 5'b00000, s[1:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold KEY low until step moves (bounded), then release and let it settle.
  task automatic do_press(input logic [5:0] sw_val, input bit scramble,
                          output logic [5:0] used, output bit seen);
    logic [3:0] old_step;
    old_step = step;
    seen = 1'b0;
    used = sw_val;
    KEY = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      used = scramble ? 6'($urandom) : sw_val;
      SW = used;
      @(negedge clk);
      if (step != old_step) seen = 1'b1;
    end
    for (int c = 0; c < 4; c++) begin
      SW = 6'($urandom);
      @(negedge clk);
    end
    KEY = 1'b1;
    for (int c = 0; c < DEB + 12; c++) begin
      SW = 6'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] used;
    logic [5:0] used2;
    bit         seen;

    vecs[0] = '{6'b000011, 4'd1, 1'b1, 1'b0};
    vecs[1] = '{{OP_SUB, 4'b0000}, 4'd2, 1'b0, 1'b0};
    vecs[2] = '{6'b000110, 4'd3, 1'b1, 1'b0};
    vecs[3] = '{{OP_MUL, 4'b0000}, 4'd4, 1'b0, 1'b0};
    vecs[4] = '{6'b000001, 4'd5, 1'b1, 1'b0};
    vecs[5] = '{{OP_DIV, 4'b0000}, 4'd6, 1'b0, 1'b0};
    vecs[6] = '{6'b000010, 4'd7, 1'b1, 1'b0};
    vecs[7] = '{{OP_ADD, 4'b0000}, 4'd8, 1'b0, 1'b0};
    vecs[8] = '{6'b000101, 4'd9, 1'b0, 1'b1};

    rst_n = 1'b0;
    KEY = 1'b0;
    SW = 6'b0;
    consume = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_numbers", numbers, 0);
    check("rst_operators", operators, 0);
    check("rst_valid", valid, 0);
    check("rst_step", step, 0);
    check("rst_expect_op", expect_op, 0);
    KEY = 1'b1;
    rst_n = 1'b1;
    repeat (DEB + 12) @(negedge clk);
    check("rst_no_press", step, 0);

    for (int i = 0; i < 9; i++) begin
      do_press(vecs[i].sw, 1'b0, used, seen);
      check($sformatf("entry%0d_seen", i), seen, 1);
      check($sformatf("entry%0d_step", i), step, vecs[i].step);
      check($sformatf("entry%0d_expect_op", i), expect_op, vecs[i].eop);
      check($sformatf("entry%0d_valid", i), valid, vecs[i].vld);
    end
    check("full_numbers", numbers, 40'h81_02_01_82_03);
    check("full_operators", operators, 8'b00_11_10_01);

    do_press(6'b000111, 1'b0, used, seen);
    check("full_press_ignored_seen", seen, 0);
    check("full_press_numbers", numbers, 40'h81_02_01_82_03);
    check("full_press_operators", operators, 8'b00_11_10_01);
    check("full_press_valid", valid, 1);

    // consume lands in the same cycle as the press pulse
    SW = 6'b000011;
    KEY = 1'b0;
    repeat (PRESS_LAT) @(negedge clk);
    consume = 1'b1;
    @(negedge clk);
    consume = 1'b0;
    check("consume_valid", valid, 0);
    check("consume_step", step, 0);
    check("consume_numbers", numbers, 0);
    check("consume_operators", operators, 0);
    repeat (4) @(negedge clk);
    KEY = 1'b1;
    repeat (DEB + 12) @(negedge clk);
    check("consume_press_dropped", step, 0);

    do_press(6'b000001, 1'b0, used, seen);
    consume = 1'b1;
    @(negedge clk);
    consume = 1'b0;
    @(negedge clk);
    check("consume_ignored_step", step, 1);
    check("consume_ignored_numbers", numbers, 40'h01);

    for (int i = 0; i < 4; i++) do_press(6'b010010, 1'b0, used, seen);
    check("midentry_step", step, 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_numbers", numbers, 0);
    check("midrst_operators", operators, 0);
    check("midrst_step", step, 0);
    do_press(6'b000111, 1'b0, used, seen);
    check("after_rst_numbers", numbers, 40'h83);
    check("after_rst_step", step, 1);

    do_press(6'b0, 1'b1, used, seen);
    check("sw_sample_op", operators[1:0], used[5:4]);
    do_press(6'b0, 1'b1, used2, seen);
    check("sw_sample_num", numbers[15:8], exp_byte(used2));
    check("sw_sample_op_kept", operators[1:0], used[5:4]);

`ifdef CALC_ENTRY_DEBOUNCE_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    SW = 6'b000011;
    KEY = 1'b1;
    for (int c = 0; c < 21; c++) begin
      if (c % 3 == 0) KEY = ~KEY;
      @(negedge clk);
    end
    check("bounce_no_early_press", step, 0);
    KEY = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (step != 4'd0) seen = 1'b1;
    end
    check("bounce_seen", seen, 1);
    repeat (20) @(negedge clk);
    for (int c = 0; c < 21; c++) begin
      if (c % 3 == 0) KEY = ~KEY;
      @(negedge clk);
    end
    KEY = 1'b1;
    repeat (DEB + 12) @(negedge clk);
    check("bounce_step", step, 1);
    check("bounce_numbers", numbers, 40'h03);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
